// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding req/ack memory port, prefetch queue, stall and redirect.
// Define FETCH_UNIT_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    STEP        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_ack,
    input  logic [INSTR_WIDTH-1:0]        mem_rdata,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [INSTR_WIDTH-1:0]        instr_out,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    output logic [ADDR_WIDTH-1:0]         pc_value,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  q_pc   [DEPTH];
    logic [INSTR_WIDTH-1:0] q_data [DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;

    logic                   ack_wait, bypass, push, pop, launch;
    logic [CW:0]            count_next;
    logic [ADDR_WIDTH-1:0]  next_addr, launch_addr;

    always_comb begin
        ack_wait  = (state == WAIT) && mem_ack;
        next_addr = mem_addr + ADDR_WIDTH'(STEP);
`ifdef FETCH_UNIT_BYPASS_EN
        bypass    = (count == '0) && ack_wait && !redirect_valid;
`else
        bypass    = 1'b0;
`endif
        // A bypassed response that decode takes right away never enters the queue.
        push        = ack_wait && !redirect_valid && !(bypass && instr_ready);
        pop         = (count != '0) && instr_ready;
        count_next  = (CW+1)'(count) + (CW+1)'(push) - (CW+1)'(pop);
        // Reserving a slot at launch time is what keeps the queue from overflowing.
        launch      = enable && !redirect_valid && (count_next < (CW+1)'(DEPTH));
        launch_addr = ack_wait ? next_addr : pc_value;
    end

    always_comb begin
        instr_valid = (count != '0) || bypass;
        instr_out   = bypass ? mem_rdata : q_data[rd_ptr];
        instr_pc    = bypass ? mem_addr  : q_pc[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            pc_value <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pc_value <= redirect_pc;
            // An in-flight request must still be retired; its data is thrown away.
            case (state)
                WAIT, DRAIN: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state   <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (push) begin
                q_pc[wr_ptr]   <= mem_addr;
                q_data[wr_ptr] <= mem_rdata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_next[CW-1:0];
            if (ack_wait)
                pc_value <= next_addr;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= launch_addr;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (launch) begin
                            mem_addr <= launch_addr;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall, streaming, backpressure, redirect and bypass.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_value;
    logic [2:0]  count;

    int   lat = 1;
    logic ack_tied = 1'b0;
    int   lat_cnt = 0;
    int   n_chk = 0;
    int   n_err = 0;

`ifdef FETCH_UNIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fetch_unit dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .pc_value(pc_value), .count(count)
    );

    always #5 clk = ~clk;

    // Memory model: fixed latency in cycles, data derived from the address.
    assign mem_rdata = mem_addr ^ 32'hA5A50000;
    assign mem_ack   = ack_tied | (mem_req && (lat_cnt == lat - 1));
    always @(posedge clk) begin
        if (!mem_req || mem_ack) lat_cnt <= 0;
        else                     lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic tied, input logic rdy, input logic en);
        lat            = l;
        ack_tied       = tied;
        instr_ready    = rdy;
        redirect_valid = 1'b0;
        enable         = 1'b0;
        reset          = 1'b0;
        step();
        step();
        reset  = 1'b1;
        enable = en;
    endtask

    initial begin
        int   got;
        logic found;
        logic saw8;

        // Asynchronous reset values, no clock edge yet
        #2 reset = 1'b0;
        #1;
        chk("rst_req",   mem_req, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_pc",    pc_value, 32'h0);
        chk("rst_out",   instr_out, 32'h0);
        chk("rst_ipc",   instr_pc, 32'h0);

        // enable low blocks launches
        do_reset(1, 1'b0, 1'b1, 1'b0);
        step(); step();
        chk("en0_req", mem_req, 1'b0);
        enable = 1'b1;
        step();
        chk("en1_req",  mem_req, 1'b1);
        chk("en1_addr", mem_addr, 32'h0);

        // Streaming with zero-wait memory
        do_reset(1, 1'b1, 1'b1, 1'b1);
        step();
        chk("str_req",  mem_req, 1'b1);
        chk("str_addr", mem_addr, 32'h0);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("str_valid", instr_valid, 1'b1);
            chk("str_pc",    instr_pc, 32'(4 * (k - 2 + int'(BYP))));
            chk("str_data",  instr_out, 32'(4 * (k - 2 + int'(BYP))) ^ 32'hA5A50000);
        end

        // Backpressure: fill the queue, then drain
        do_reset(1, 1'b1, 1'b0, 1'b1);
        repeat (6) step();
        chk("bp_count", count, 3'd4);
        chk("bp_req",   mem_req, 1'b0);
        chk("bp_pc",    pc_value, 32'h10);
        instr_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (instr_valid) begin
                chk("bp_pop_pc", instr_pc, 32'(4 * got));
                got++;
            end
            step();
        end
        chk("bp_pops", got, 8);

        // Reset mid-request with two entries queued
        do_reset(2, 1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (count == 3'd2 && mem_req) found = 1'b1;
        end
        chk("mrst_setup", found, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mrst_req",   mem_req, 1'b0);
        chk("mrst_count", count, 3'd0);
        chk("mrst_valid", instr_valid, 1'b0);
        chk("mrst_addr",  mem_addr, 32'h0);

        // Redirect while the request to 8 is in flight (latency 3)
        do_reset(3, 1'b0, 1'b1, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            if (mem_req && mem_addr == 32'h8) found = 1'b1;
        end
        chk("rdr_setup", found, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("rdr_count", count, 3'd0);
        chk("rdr_pc",    pc_value, 32'h100);
        chk("rdr_drain", mem_req, 1'b1);
        chk("rdr_v0",    instr_valid, 1'b0);
        step();
        chk("rdr_idle",  mem_req, 1'b0);
        chk("rdr_v1",    instr_valid, 1'b0);
        step();
        chk("rdr_req",   mem_req, 1'b1);
        chk("rdr_addr",  mem_addr, 32'h100);
        found = 1'b0;
        saw8  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (instr_valid) begin
                found = 1'b1;
                if (instr_pc == 32'h8) saw8 = 1'b1;
                chk("rdr_first_pc",   instr_pc, 32'h100);
                chk("rdr_first_data", instr_out, 32'h100 ^ 32'hA5A50000);
            end else begin
                step();
            end
        end
        chk("rdr_seen",  found, 1'b1);
        chk("rdr_stale", saw8, 1'b0);

        // Redirect, ack and pop all in one cycle with two entries queued
        do_reset(1, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        chk("sim_setup", count, 3'd2);
        chk("sim_ack",   mem_ack, 1'b1);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("sim_count", count, 3'd0);
        chk("sim_valid", instr_valid, 1'b0);
        chk("sim_idle",  mem_req, 1'b0);
        step();
        chk("sim_req",   mem_req, 1'b1);
        chk("sim_addr",  mem_addr, 32'h40);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (instr_valid) begin
                found = 1'b1;
                chk("sim_first_pc", instr_pc, 32'h40);
            end else begin
                step();
            end
        end
        chk("sim_seen", found, 1'b1);

        // Empty queue, latency 2: bypass shows data in the ack cycle
        do_reset(2, 1'b0, 1'b1, 1'b1);
        step();
        chk("byp_req", mem_req, 1'b1);
        step();
        chk("byp_ack",    mem_ack, 1'b1);
        chk("byp_valid0", instr_valid, BYP);
        chk("byp_count0", count, 3'd0);
        step();
        chk("byp_valid1", instr_valid, !BYP);
        chk("byp_count1", count, BYP ? 3'd0 : 3'd1);
        chk("byp_addr1",  mem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
